spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_controller_if.sv | 28 ++
 rtl/spi_sclk_div.sv | 33 +++
 rtl/spi_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: FSM states, frame
// geometry and the peripheral's register map.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;

    localparam logic [ADDR_W-1:0] EN_OUT_7_0         = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_15_8        = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_MODE_7_0    = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_MODE_15_8   = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY_CYCLE_7_0 = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [FRAME_W-1:0] f;
        f         = {1'b0, addr, wdata};
        f[RW_BIT] = rw;
        return f;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Host request/response and SPI pin bundle for spi_controller.
// master = controller view, slave = host/peripheral view.
interface spi_controller_if;
    import spi_pkg::*;

    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              SCLK;
    logic              nCS;
    logic              COPI;
    logic              CIPO;

    modport master (
        input  start, rw, addr, wdata, CIPO,
        output busy, done, rdata, SCLK, nCS, COPI
    );

    modport slave (
        output start, rw, addr, wdata, CIPO,
        input  busy, done, rdata, SCLK, nCS, COPI
    );

endinterface

// File: rtl/spi_sclk_div.sv
// Half-period timer: reloads to CLK_DIV-1 on load or terminal count and
// flags tc_o on the last cycle of every CLK_DIV-cycle period.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tc_o
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 8'd1;
        if (load_i || cnt_q == 8'd0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame controller sending {rw, addr, wdata} MSB first.
// Define SPI_CONTROLLER_READ_EN to transmit rw as given and capture read data from CIPO.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input logic              clk,
    input logic              rst_n,
    spi_controller_if.master bus
);

    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               div_load;
    logic               div_tc;
    logic               sclk_rise;
    logic               frame_done;
    logic               accept;
    logic               tx_rw;

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (div_load),
        .tc_o   (div_tc)
    );

    assign accept = (state_q == ST_IDLE) && bus.start;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        gap_cnt_d  = gap_cnt_q;
        div_load   = 1'b0;
        sclk_rise  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SETUP;
                    shreg_d   = build_frame(tx_rw, bus.addr, bus.wdata);
                    bit_cnt_d = '0;
                    div_load  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_tc) begin
                    state_d   = ST_SHIFT;
                    sclk_d    = 1'b1;
                    sclk_rise = 1'b1;
                end
            end
            ST_SHIFT: begin
                // COPI advances only as SCLK falls; zeros shift in so the line idles low afterwards
                if (div_tc) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    end else if (bit_cnt_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sclk_d    = 1'b1;
                        sclk_rise = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (div_tc) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef SPI_CONTROLLER_READ_EN
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rw_q, rw_d;

    assign tx_rw = bus.rw;

    // rdata updates as the gap begins so it is already valid while done pulses
    always_comb begin
        rx_d    = rx_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        if (sclk_rise) begin
            rx_d = {rx_q[DATA_W-2:0], bus.CIPO};
        end
        if (accept) begin
            rw_d = bus.rw;
        end
        if (state_q == ST_HOLD && div_tc && !rw_q) begin
            rdata_d = rx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q    <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
`else
    logic unused_sink;

    assign tx_rw       = 1'b1;
    assign bus.rdata   = '0;
    assign unused_sink = bus.rw ^ bus.CIPO ^ sclk_rise ^ accept;
`endif

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = frame_done;
    assign bus.SCLK = sclk_q;
    assign bus.nCS  = ~((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    assign bus.COPI = shreg_q[FRAME_W-1];

endmodule
